bus: RTL and testbench

BUS -- requirements
Module: bus

---
 rtl/bus_pkg.sv | 9 +
 rtl/bus.sv | 153 +++++++++++++++
 tb/tb_bus.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared helpers for the bus block.
//   idx_w(n) : bit width needed to index n items, never less than 1.
package bus_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus.sv
// Single-cycle request bus: fixed-priority host arbitration, address decode
// to one of NrDevices targets, and a registered response mux.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   host_req_i / host_gnt_o         per-host request / same-cycle grant
//   host_addr_i/we/be/wdata         per-host request fields
//   host_rvalid_o/rdata_o/err_o     per-host response, one cycle after grant
//   device_req_o/addr/we/be/wdata   per-device forwarded request
//   device_rvalid_i/rdata_i/err_i   per-device response
//   cfg_device_addr_base/mask       static address map
module bus
  import bus_pkg::*;
#(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],

  output logic                      device_req_o    [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
  output logic                      device_we_o     [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
  input  logic                      device_rvalid_i [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
  input  logic                      device_err_i    [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = idx_w(NrHosts);
  localparam int DevIdxW  = idx_w(NrDevices);

  logic                  any_req;
  logic [HostIdxW-1:0]   host_sel;
  logic                  dev_hit;
  logic [DevIdxW-1:0]    dev_sel;
  logic [AddressWidth-1:0] win_addr;

  logic                  pend_q;
  logic                  err_q;
  logic [HostIdxW-1:0]   host_q;
  logic [DevIdxW-1:0]    dev_q;

  // Arbiter: lowest-index requester wins.
  always_comb begin
    any_req  = 1'b0;
    host_sel = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (host_req_i[h] && !any_req) begin
        any_req  = 1'b1;
        host_sel = HostIdxW'(h);
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NrHosts; h++)
      host_gnt_o[h] = any_req && (host_sel == HostIdxW'(h));
  end

  // Decoder on the winner's address; lowest-index match wins.
  always_comb begin
    win_addr = '0;
    for (int h = 0; h < NrHosts; h++)
      if (host_sel == HostIdxW'(h)) win_addr = host_addr_i[h];
    dev_hit = 1'b0;
    dev_sel = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!dev_hit && ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dev_hit = 1'b1;
        dev_sel = DevIdxW'(d);
      end
    end
  end

  // Request forwarding: only the selected device sees non-zero outputs.
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = 1'b0;
      device_addr_o[d]  = '0;
      device_we_o[d]    = 1'b0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
      if (any_req && dev_hit && (dev_sel == DevIdxW'(d))) begin
        for (int h = 0; h < NrHosts; h++) begin
          if (host_sel == HostIdxW'(h)) begin
            device_req_o[d]   = 1'b1;
            device_addr_o[d]  = host_addr_i[h];
            device_we_o[d]    = host_we_i[h];
            device_be_o[d]    = host_be_i[h];
            device_wdata_o[d] = host_wdata_i[h];
          end
        end
      end
    end
  end

  // Select register: remembers who owns next cycle's response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      host_q <= '0;
      dev_q  <= '0;
    end else begin
      pend_q <= any_req;
      err_q  <= any_req && !dev_hit;
      host_q <= host_sel;
      dev_q  <= dev_sel;
    end
  end

  // Response mux. Device responses are ignored unless a grant is pending,
  // so stray rvalids from idle devices never reach a host. Reset is folded
  // in so an in-flight response is killed the moment rst_i rises.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (!rst_i && pend_q && (host_q == HostIdxW'(h))) begin
        if (err_q) begin
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = 1'b1;
        end else begin
          for (int d = 0; d < NrDevices; d++) begin
            if (dev_q == DevIdxW'(d)) begin
              host_rvalid_o[h] = device_rvalid_i[d];
              host_rdata_o[h]  = device_rdata_i[d];
              host_err_o[h]    = device_err_i[d];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus.sv
// Directed self-checking bench for bus with 2 hosts and 3 devices.
module tb_bus;

  localparam int NH = 2;
  localparam int ND = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        host_req_i    [NH];
  logic        host_gnt_o    [NH];
  logic [31:0] host_addr_i   [NH];
  logic        host_we_i     [NH];
  logic [3:0]  host_be_i     [NH];
  logic [31:0] host_wdata_i  [NH];
  logic        host_rvalid_o [NH];
  logic [31:0] host_rdata_o  [NH];
  logic        host_err_o    [NH];
  logic        device_req_o    [ND];
  logic [31:0] device_addr_o   [ND];
  logic        device_we_o     [ND];
  logic [3:0]  device_be_o     [ND];
  logic [31:0] device_wdata_o  [ND];
  logic        device_rvalid_i [ND];
  logic [31:0] device_rdata_i  [ND];
  logic        device_err_i    [ND];
  logic [31:0] cfg_device_addr_base [ND];
  logic [31:0] cfg_device_addr_mask [ND];

  int checks = 0;
  int errors = 0;

  bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base(cfg_device_addr_base), .cfg_device_addr_mask(cfg_device_addr_mask)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = 1'b0; host_addr_i[h] = '0; host_we_i[h] = 1'b0;
      host_be_i[h] = '0; host_wdata_i[h] = '0;
    end
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 1'b0; device_rdata_i[d] = '0; device_err_i[d] = 1'b0;
    end
  endtask

  task automatic req(input int h, input logic [31:0] a, input logic we,
                     input logic [3:0] be, input logic [31:0] wd);
    host_req_i[h] = 1'b1; host_addr_i[h] = a; host_we_i[h] = we;
    host_be_i[h] = be; host_wdata_i[h] = wd;
  endtask

  task automatic rsp(input int d, input logic [31:0] rd);
    device_rvalid_i[d] = 1'b1; device_rdata_i[d] = rd;
  endtask

  initial begin
    cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = ~32'h000F_FFFF;
    cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = ~32'h0000_03FF;
    cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = ~32'h0000_03FF;
    idle();
    rst_i = 1'b1;

    // Reset state, with a stray device rvalid that must not leak through.
    rsp(0, 32'h1234);
    @(negedge clk_i);
    check("rst_rvalid0", host_rvalid_o[0], 0);
    check("rst_err0", host_err_o[0], 0);
    check("rst_gnt0", host_gnt_o[0], 0);
    step();
    idle();
    rst_i = 1'b0;

    // Host0 read dev0.
    step();
    req(0, 32'h0010_0040, 1'b0, 4'hF, 0);
    @(negedge clk_i);
    check("rd0_gnt0", host_gnt_o[0], 1);
    check("rd0_gnt1", host_gnt_o[1], 0);
    check("rd0_dreq0", device_req_o[0], 1);
    check("rd0_daddr0", device_addr_o[0], 32'h0010_0040);
    check("rd0_dreq1", device_req_o[1], 0);
    check("rd0_daddr1", device_addr_o[1], 0);
    step();
    idle();
    rsp(0, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("rd0_rvalid", host_rvalid_o[0], 1);
    check("rd0_rdata", host_rdata_o[0], 32'hDEAD_BEEF);
    check("rd0_err", host_err_o[0], 0);
    check("rd0_h1_rvalid", host_rvalid_o[1], 0);

    // Host0 write dev1.
    step();
    idle();
    req(0, 32'h0002_0000, 1'b1, 4'hF, 32'h41);
    @(negedge clk_i);
    check("wr_dreq0", device_req_o[0], 0);
    check("wr_dreq1", device_req_o[1], 1);
    check("wr_dreq2", device_req_o[2], 0);
    check("wr_we1", device_we_o[1], 1);
    check("wr_wdata1", device_wdata_o[1], 32'h41);
    check("wr_be1", device_be_o[1], 4'hF);
    step();
    idle();
    rsp(1, 0);
    @(negedge clk_i);
    check("wr_rvalid", host_rvalid_o[0], 1);
    check("wr_err", host_err_o[0], 0);

    // Unmapped read: bus-generated error.
    step();
    idle();
    req(0, 32'h0004_0000, 1'b0, 4'hF, 0);
    @(negedge clk_i);
    check("um_gnt0", host_gnt_o[0], 1);
    check("um_dreq", {device_req_o[0], device_req_o[1], device_req_o[2]}, 0);
    step();
    idle();
    @(negedge clk_i);
    check("um_rvalid", host_rvalid_o[0], 1);
    check("um_err", host_err_o[0], 1);
    check("um_rdata", host_rdata_o[0], 0);

    // Idle cycle then check no response even with a stray device rvalid.
    step();
    idle();
    @(negedge clk_i);
    check("idle_gnt", {host_gnt_o[0], host_gnt_o[1]}, 0);
    check("idle_dreq", {device_req_o[0], device_req_o[1], device_req_o[2]}, 0);
    step();
    rsp(0, 32'h77);
    @(negedge clk_i);
    check("idle_rvalid0", host_rvalid_o[0], 0);
    check("idle_err0", host_err_o[0], 0);

    // Two hosts contend: host0 wins.
    step();
    idle();
    req(0, 32'h0003_0004, 1'b0, 4'hF, 0);
    req(1, 32'h0010_0000, 1'b0, 4'hF, 0);
    @(negedge clk_i);
    check("arb_gnt0", host_gnt_o[0], 1);
    check("arb_gnt1", host_gnt_o[1], 0);
    check("arb_dreq2", device_req_o[2], 1);
    check("arb_daddr2", device_addr_o[2], 32'h0003_0004);
    check("arb_dreq0", device_req_o[0], 0);
    step();
    idle();
    rsp(2, 32'h33);
    rsp(0, 32'h99);
    @(negedge clk_i);
    check("arb_rvalid0", host_rvalid_o[0], 1);
    check("arb_rdata0", host_rdata_o[0], 32'h33);
    check("arb_rvalid1", host_rvalid_o[1], 0);
    check("arb_rdata1", host_rdata_o[1], 0);

    // Host1 alone to dev1: response routed to host1 only.
    step();
    idle();
    req(1, 32'h0002_0010, 1'b0, 4'h3, 0);
    @(negedge clk_i);
    check("h1_gnt1", host_gnt_o[1], 1);
    check("h1_be1", device_be_o[1], 4'h3);
    step();
    idle();
    rsp(1, 32'h55);
    @(negedge clk_i);
    check("h1_rvalid1", host_rvalid_o[1], 1);
    check("h1_rdata1", host_rdata_o[1], 32'h55);
    check("h1_rvalid0", host_rvalid_o[0], 0);

    // Back-to-back: dev0 then dev2.
    step();
    idle();
    req(0, 32'h0010_0000, 1'b0, 4'hF, 0);
    @(negedge clk_i);
    check("b2b_dreq0", device_req_o[0], 1);
    step();
    idle();
    req(0, 32'h0003_0000, 1'b0, 4'hF, 0);
    rsp(0, 32'h1111_0000);
    @(negedge clk_i);
    check("b2b_rdata_a", host_rdata_o[0], 32'h1111_0000);
    check("b2b_rvalid_a", host_rvalid_o[0], 1);
    check("b2b_dreq2", device_req_o[2], 1);
    step();
    idle();
    rsp(2, 32'h2222_0000);
    @(negedge clk_i);
    check("b2b_rvalid_b", host_rvalid_o[0], 1);
    check("b2b_rdata_b", host_rdata_o[0], 32'h2222_0000);

    // Reset mid-flight drops the response immediately.
    step();
    idle();
    req(0, 32'h0010_0000, 1'b0, 4'hF, 0);
    step();
    idle();
    rsp(0, 32'hABCD);
    rst_i = 1'b1;
    #1;
    check("mid_rst_rvalid", host_rvalid_o[0], 0);
    check("mid_rst_rdata", host_rdata_o[0], 0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_rvalid", host_rvalid_o[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
